// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//   Sequencer for an iterative shift-subtract divider datapath. A Start pulse
//   produces one Load cycle and then WIDTH consecutive W_ctrl cycles. After that
//   the result is held in DONE (Ready=1) until the consumer acknowledges it.
//
//   Handshake: Ready=1 means a result is valid and stays high until Ack=1 or
//   Abort=1 is sampled on a rising clk edge. Ack together with Start in DONE
//   starts the next divide directly in LOAD, with no IDLE cycle between the
//   two operations. Start is only accepted in IDLE, and in DONE together with
//   Ack. It is ignored in LOAD and RUN and is not remembered for later.
//
//   Optional feature macro: DIV_ZERO_CHK_EN
//     defined   - DivByZero is captured together with an accepted Start. A
//                 zero divisor skips the iterations (LOAD -> DONE) and
//                 reports Err=1 together with Ready.
//     undefined - DivByZero is ignored, Err is always 0.
//
// Ports
//   clk        clock, rising edge
//   Reset      asynchronous, active-high reset
//   Start      request a new divide
//   Abort      cancel the operation in progress (also releases DONE)
//   Ack        consumer took the result; releases DONE
//   DivByZero  divisor-is-zero flag, sampled with Start
//   Load       load operands / clear remainder (one cycle)
//   W_ctrl     iteration write/shift enable
//   Iter       current iteration index, 0..WIDTH-1
//   Busy       high in LOAD and RUN
//   Ready      result valid (DONE)
//   Err        divide-by-zero result, qualified by Ready
//   dbg_state  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Ack,
  input  logic             DivByZero,
  output logic             Load,
  output logic             W_ctrl,
  output logic [CNT_W-1:0] Iter,
  output logic             Busy,
  output logic             Ready,
  output logic             Err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             dbz_in;

  // With the check disabled the flag is masked to 0, so err_q stays 0 and
  // the LOAD -> DONE shortcut below can never be taken.
`ifdef DIV_ZERO_CHK_EN
  assign dbz_in = DivByZero;
`else
  assign dbz_in = DivByZero & 1'b0;
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= LOAD;
            err_q <= dbz_in;
          end
        end

        LOAD: begin
          if (Abort) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
          end else if (err_q) begin
            // Zero divisor: no iterations. Park the index at its final
            // value so Iter in DONE reads the same as after a full run.
            state <= DONE;
            cnt   <= LAST;
          end else begin
            state <= RUN;
            cnt   <= '0;
          end
        end

        RUN: begin
          if (Abort) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
          end else if (cnt == LAST) begin
            // The index holds at WIDTH-1 and never wraps.
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // Abort wins over Ack and Start. Start without Ack is ignored so
          // the pending result is not overwritten.
          if (Abort) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
          end else if (Ack) begin
            cnt <= '0;
            if (Start) begin
              state <= LOAD;
              err_q <= dbz_in;
            end else begin
              state <= IDLE;
              err_q <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  // Moore decode from the state register. An asynchronous reset therefore
  // clears every output immediately. cnt is already 0 in IDLE and LOAD.
  assign Load      = (state == LOAD);
  assign W_ctrl    = (state == RUN);
  assign Busy      = (state == LOAD) || (state == RUN);
  assign Ready     = (state == DONE);
  assign Err       = (state == DONE) && err_q;
  assign Iter      = cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH);
`ifdef DIV_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic          clk;
  logic          Reset;
  logic          Start;
  logic          Abort;
  logic          Ack;
  logic          DivByZero;
  logic          Load;
  logic          W_ctrl;
  logic [CW-1:0] Iter;
  logic          Busy;
  logic          Ready;
  logic          Err;
  logic [1:0]    dbg_state;

  div_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Start     (Start),
    .Abort     (Abort),
    .Ack       (Ack),
    .DivByZero (DivByZero),
    .Load      (Load),
    .W_ctrl    (W_ctrl),
    .Iter      (Iter),
    .Busy      (Busy),
    .Ready     (Ready),
    .Err       (Err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total;
  int bad;
  logic [31:0] exp_load_q[$];   // cycle at which Load must be seen
  logic [31:0] exp_ready_q[$];  // cycle at which Ready must rise
  logic        exp_err_q[$];    // Err value expected with that Ready

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {Load, W_ctrl, Busy, Ready, Err, 32'(Iter)}, 64'd0);
  endtask

  // ---------------- monitor ----------------
  logic ready_prev;
  int   cur_load;
  initial begin
    ready_prev = 1'b0;
    cur_load   = 0;
  end

  always @(negedge clk) begin
    if (Reset) begin
      ready_prev = 1'b0;
    end else begin
      // Busy covers exactly LOAD and RUN; Err only with Ready; Ready never while busy.
      chk("busy_rule", {Busy, Ready & Busy, Err & ~Ready}, {Load | W_ctrl, 1'b0, 1'b0});
      if (Load) begin
        if (exp_load_q.size() == 0) fail_now("unexpected_load", cyc, -1);
        else begin
          cur_load = int'(exp_load_q.pop_front());
          chk("load_cycle", cyc, cur_load);
          chk("load_iter", Iter, 0);
        end
      end
      if (W_ctrl) chk("run_iter", Iter, cyc - cur_load - 1);
      if (!Load && !W_ctrl && !Ready) chk("idle_iter", Iter, 0);
      if (Ready && !ready_prev) begin
        if (exp_ready_q.size() == 0) fail_now("unexpected_ready", cyc, -1);
        else begin
          chk("ready_cycle", cyc, exp_ready_q.pop_front());
          chk("ready_err", Err, exp_err_q.pop_front());
        end
      end
      if (Ready) chk("done_iter", Iter, WIDTH - 1);
      ready_prev = Ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Issue an accepted Start (optionally with Ack for back-to-back) and
  // record the expected timeline. Returns on the negedge where Load shows.
  task automatic start_op(input logic dbz, input logic with_ack);
    int ld;
    ld = cyc + 1;
    exp_load_q.push_back(32'(ld));
    if (ZCHK && dbz) begin
      exp_ready_q.push_back(32'(ld + 1));
      exp_err_q.push_back(1'b1);
    end else begin
      exp_ready_q.push_back(32'(ld + WIDTH + 1));
      exp_err_q.push_back(1'b0);
    end
    Start = 1'b1; DivByZero = dbz; Ack = with_ack;
    tick();
    Start = 1'b0; DivByZero = 1'b0; Ack = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!Ready && n < WIDTH + 8) begin
      tick();
      n++;
    end
    if (!Ready) fail_now("ready_timeout", n, WIDTH + 8);
  endtask

  // Hold DONE a few cycles with stray Starts (must be ignored), then release.
  task automatic hold_and_ack();
    int n;
    n = $urandom_range(0, 4);
    repeat (n) begin
      Start = 1'($urandom_range(0, 1));
      tick();
      Start = 1'b0;
    end
    chk("ready_held", Ready, 1'b1);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk("ready_released", Ready, 1'b0);
  endtask

  task automatic wait_iter(input int idx, output bit found);
    int n;
    n = 0;
    found = 0;
    while (!(W_ctrl && Iter == CW'(idx)) && n < WIDTH + 4) begin
      tick();
      n++;
    end
    found = W_ctrl && (Iter == CW'(idx));
    if (!found) fail_now("iter_timeout", n, idx);
  endtask

  task automatic abort_now();
    void'(exp_ready_q.pop_back());
    void'(exp_err_q.pop_back());
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("after_abort", {W_ctrl, Busy, Ready, 32'(Iter)}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit in_done;
    bit found;
    total = 0;
    bad   = 0;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Ack = 1'b0; DivByZero = 1'b0;
    tick();
    chk_all_zero("reset_outputs");
    Start = 1'b1;
    tick();
    chk_all_zero("reset_outputs_with_start");
    Start = 1'b0;
    Reset = 1'b0;
    tick();
    Ack = 1'b1; Abort = 1'b1;  // ignored in IDLE
    tick();
    Ack = 1'b0; Abort = 1'b0;
    chk_all_zero("idle_after_release");

    // Basic op with a stray Start in RUN (ignored, not queued).
    start_op(1'b0, 1'b0);
    repeat (3) tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_ready();
    hold_and_ack();

    // Abort at Iter=10, then a normal op.
    start_op(1'b0, 1'b0);
    wait_iter(10, found);
    if (found) abort_now();
    repeat (2) tick();
    start_op(1'b0, 1'b0);
    wait_ready();

    // Back-to-back: Ack and Start in the same cycle.
    repeat (2) tick();
    start_op(1'b0, 1'b1);
    wait_ready();
    // Abort in DONE together with Start and Ack: Abort wins.
    Abort = 1'b1; Start = 1'b1; Ack = 1'b1;
    tick();
    Abort = 1'b0; Start = 1'b0; Ack = 1'b0;
    chk("done_abort", {Ready, Load, Busy}, 3'b000);

    // Divide by zero flag.
    start_op(1'b1, 1'b0);
    wait_ready();
    hold_and_ack();

    // Asynchronous reset mid-RUN at Iter=20.
    start_op(1'b0, 1'b0);
    wait_iter(20, found);
    #2 Reset = 1'b1;
    #1 chk_all_zero("async_reset_immediate");
    exp_load_q.delete();
    exp_ready_q.delete();
    exp_err_q.delete();
    tick();
    tick();
    Reset = 1'b0;
    repeat (3) tick();
    chk_all_zero("idle_after_async_reset");

    // Randomized sequence.
    in_done = 0;
    for (int k = 0; k < 20; k++) begin
      logic dbz;
      bit   b2b;
      int   ab;
      dbz = ($urandom_range(0, 3) == 0);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
      b2b = in_done && ($urandom_range(0, 1) == 1);
      if (in_done && !b2b) hold_and_ack();
      repeat ($urandom_range(0, 2)) tick();
      start_op(dbz, b2b);
      if (ab >= 0 && !(ZCHK && dbz)) begin
        wait_iter(ab, found);
        if (found) abort_now();
        in_done = 0;
      end else begin
        wait_ready();
        in_done = 1;
      end
    end
    if (in_done) hold_and_ack();

    repeat (4) tick();
    chk("leftover_loads", exp_load_q.size(), 0);
    chk("leftover_results", exp_ready_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
